product_accumulator: RTL and testbench

Sequential stage directly downstream of `multiplier2x2`. It consumes the 4-bit `product` stream one sample per handshake and sums a fixed-length frame of products. It presents the frame total, with a sticky overflow flag, on a valid/ready output port. It is the accumulate half of the team's multiply-accumulate datapath.

---
 rtl/product_accumulator.sv | 113 +++++++++++
 tb/tb_product_accumulator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums fixed-length frames of unsigned products with sticky overflow
module product_accumulator #(
    parameter int PRODUCT_WIDTH = 4,
    parameter int FRAME_LEN     = 4,
    parameter int ACC_WIDTH     = 6,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     clear,
    input  logic [PRODUCT_WIDTH-1:0] product,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [ACC_WIDTH-1:0]     sum,
    output logic                     overflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_WIDTH-1:0]     sample_count
);

    // Adder is one bit wider than the larger operand so any carry past ACC_WIDTH is visible.
    localparam int SUM_W = ((ACC_WIDTH > PRODUCT_WIDTH) ? ACC_WIDTH : PRODUCT_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(FRAME_LEN - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   sum_q, sum_d;
    logic                   overflow_q, overflow_d;

    logic [SUM_W-1:0]       wide_sum;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic                   carry;

    assign wide_sum = SUM_W'(acc_q) + SUM_W'(product);
    assign acc_next = wide_sum[ACC_WIDTH-1:0];
    assign carry    = |wide_sum[SUM_W-1:ACC_WIDTH];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            sum_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        overflow_d = overflow_q;

        if (clear) begin
            // Abort wins over any transfer or result handshake in the same cycle.
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        if (cnt_q == LAST_IDX) begin
                            sum_d      = acc_next;
                            overflow_d = ovf_q | carry;
                            acc_d      = '0;
                            ovf_d      = 1'b0;
                            cnt_d      = '0;
                            state_d    = HOLD;
                        end else begin
                            acc_d = acc_next;
                            ovf_d = ovf_q | carry;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == HOLD);
    assign sum          = sum_q;
    assign overflow     = overflow_q;
    assign sample_count = cnt_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - self-checking bench for product_accumulator (6-bit and 5-bit accumulators)
module tb_product_accumulator;

    logic       Clk;
    logic       Reset;
    logic       clear;
    logic [3:0] product;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, overflow_a;
    logic [5:0] sum_a;
    logic [7:0] cnt_a;
    logic       in_ready_b, out_valid_b, overflow_b;
    logic [4:0] sum_b;
    logic [7:0] cnt_b;

    int checks = 0;
    int errors = 0;

    // Reference: list of accepted samples in the current frame, and whether a result is held.
    int frame[$];
    bit holding;
    int held_total;

    product_accumulator #(.PRODUCT_WIDTH(4), .FRAME_LEN(4), .ACC_WIDTH(6), .CNT_WIDTH(8)) dut_a (
        .Clk(Clk), .Reset(Reset), .clear(clear), .product(product), .in_valid(in_valid),
        .in_ready(in_ready_a), .sum(sum_a), .overflow(overflow_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .sample_count(cnt_a)
    );

    product_accumulator #(.PRODUCT_WIDTH(4), .FRAME_LEN(4), .ACC_WIDTH(5), .CNT_WIDTH(8)) dut_b (
        .Clk(Clk), .Reset(Reset), .clear(clear), .product(product), .in_valid(in_valid),
        .in_ready(in_ready_b), .sum(sum_b), .overflow(overflow_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .sample_count(cnt_b)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid_a"}, 32'(out_valid_a), 32'(holding));
        check({tag, ".in_ready_a"}, 32'(in_ready_a), 32'(!holding));
        check({tag, ".count_a"}, 32'(cnt_a), 32'(frame.size()));
        check({tag, ".out_valid_b"}, 32'(out_valid_b), 32'(holding));
        check({tag, ".count_b"}, 32'(cnt_b), 32'(frame.size()));
        if (holding) begin
            check({tag, ".sum_a"}, 32'(sum_a), 32'(held_total % 64));
            check({tag, ".ovf_a"}, 32'(overflow_a), 32'(held_total >= 64));
            check({tag, ".sum_b"}, 32'(sum_b), 32'(held_total % 32));
            check({tag, ".ovf_b"}, 32'(overflow_b), 32'(held_total >= 32));
        end
    endtask

    // One clock: apply inputs, step the reference on the edge, compare after it.
    task automatic cycle(input string tag, input bit v, input int p, input bit ordy, input bit clr);
        in_valid  = v;
        product   = v ? 4'(p) : 4'bxxxx;
        out_ready = ordy;
        clear     = clr;
        @(posedge Clk);
        #1;
        if (clr) begin
            holding = 1'b0;
            frame.delete();
        end else if (holding) begin
            if (ordy) holding = 1'b0;
        end else if (v) begin
            frame.push_back(p);
            if (frame.size() == 4) begin
                held_total = 0;
                foreach (frame[i]) held_total += frame[i];
                holding = 1'b1;
                frame.delete();
            end
        end
        check_all(tag);
    endtask

    task automatic send4(input string tag, input int p0, input int p1, input int p2, input int p3);
        cycle(tag, 1, p0, 1, 0);
        cycle(tag, 1, p1, 1, 0);
        cycle(tag, 1, p2, 1, 0);
        cycle(tag, 1, p3, 1, 0);
    endtask

    task automatic async_reset(input string tag);
        #2 Reset = 1'b1;
        #1;
        holding = 1'b0;
        frame.delete();
        check({tag, ".sum"}, 32'(sum_a), 0);
        check({tag, ".overflow"}, 32'(overflow_b), 0);
        check_all(tag);
        #1 Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; clear = 1'b0; in_valid = 1'b0; product = 4'bxxxx; out_ready = 1'b0;
        holding = 1'b0; held_total = 0;
        #2;
        check("reset.sum", 32'(sum_a), 0);
        check_all("reset");
        @(negedge Clk);
        Reset = 1'b0;

        // 9,9,9,9: 36 in 6 bits, wraps to 4 with overflow in 5 bits
        send4("nine", 9, 9, 9, 9);
        check("nine.sum36", 32'(sum_a), 36);
        check("nine.sum_wrap", 32'(sum_b), 4);
        check("nine.ovf_wrap", 32'(overflow_b), 1);
        cycle("nine.take", 1, 9, 1, 0);
        check("nine.in_ready_back", 32'(in_ready_a), 1);

        // overflow flag must not carry into the next frame
        send4("ones", 1, 1, 1, 1);
        check("ones.ovf_b", 32'(overflow_b), 0);
        cycle("ones.take", 0, 0, 1, 0);

        // backpressure: offered samples during HOLD are ignored
        send4("bp", 0, 2, 4, 6);
        for (int i = 0; i < 3; i++) begin
            cycle("bp.stall", 1, 15, 0, 0);
            check("bp.sum12", 32'(sum_a), 12);
        end
        cycle("bp.take", 1, 15, 1, 0);
        send4("bp.next", 1, 1, 1, 2);
        check("bp.next_sum", 32'(sum_a), 5);
        cycle("bp.next_take", 0, 0, 1, 0);

        // clear mid-frame drops the simultaneous sample
        cycle("clr.a", 1, 4, 1, 0);
        cycle("clr.b", 1, 6, 1, 0);
        check("clr.cnt2", 32'(cnt_a), 2);
        cycle("clr.hit", 1, 3, 1, 1);
        check("clr.cnt0", 32'(cnt_a), 0);
        send4("clr.frame", 1, 2, 3, 0);
        check("clr.sum6", 32'(sum_a), 6);
        cycle("clr.take", 0, 0, 1, 0);

        // clear while holding discards the result
        cycle("hclr.a", 1, 5, 0, 0);
        cycle("hclr.b", 1, 5, 0, 0);
        cycle("hclr.c", 1, 5, 0, 0);
        cycle("hclr.d", 1, 5, 0, 0);
        check("hclr.sum20", 32'(sum_a), 20);
        cycle("hclr.hold", 0, 0, 0, 0);
        cycle("hclr.clear", 0, 0, 0, 1);
        check("hclr.valid0", 32'(out_valid_a), 0);
        check("hclr.ready1", 32'(in_ready_a), 1);
        cycle("hclr.idle", 0, 0, 0, 0);

        // asynchronous reset mid-frame
        cycle("rst.a", 1, 7, 1, 0);
        cycle("rst.b", 1, 7, 1, 0);
        cycle("rst.c", 1, 7, 1, 0);
        async_reset("rst.mid");
        send4("rst.frame", 1, 3, 2, 3);
        check("rst.sum9", 32'(sum_a), 9);
        cycle("rst.take", 0, 0, 1, 0);

        // asynchronous reset while holding
        send4("rsth", 15, 15, 15, 15);
        async_reset("rsth.hold");

        // randomized traffic with gaps, backpressure and occasional clear
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom % 4) != 0, int'($urandom % 16), ($urandom % 3) != 0,
                  ($urandom % 50) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
